// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing one register-file write port among NREQ producers,
// with a per-register pending scoreboard for RAW stall detection.
module regfile_write_arbiter #(
  parameter int REG_NUM  = 32,
  parameter int REG_SIZE = 32,
  parameter int NREQ     = 3,
  localparam int AW      = $clog2(REG_NUM)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*AW-1:0]       req_addr,
  input  logic [NREQ*REG_SIZE-1:0] req_data,
  output logic                     reg_write,
  output logic [AW-1:0]            write_reg,
  output logic [REG_SIZE-1:0]      write_data,
  input  logic                     claim_valid,
  input  logic [AW-1:0]            claim_addr,
  input  logic [AW-1:0]            query_addr_1,
  input  logic [AW-1:0]            query_addr_2,
  output logic                     busy_1,
  output logic                     busy_2,
  output logic [15:0]              grant_cnt
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]       r_rr_ptr;
  logic                r_reg_write;
  logic [AW-1:0]       r_write_reg;
  logic [REG_SIZE-1:0] r_write_data;
  logic [15:0]         r_grant_cnt;
  logic [REG_NUM-1:0]  r_busy;

  logic                w_found;
  logic [PW-1:0]       w_win;
  logic [PW-1:0]       w_idx;
  logic [AW-1:0]       w_addr;
  logic [REG_SIZE-1:0] w_data;
  logic                w_xfer;

  // Scan from the round-robin pointer; first valid requester wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = PW'((int'(r_rr_ptr) + k) % NREQ);
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    w_addr    = '0;
    w_data    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_win == PW'(i)) begin
        req_ready[i] = rst_n & w_found;
        w_addr       = req_addr[i*AW +: AW];
        w_data       = req_data[i*REG_SIZE +: REG_SIZE];
      end
    end
  end

  assign w_xfer = |(req_valid & req_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr     <= '0;
      r_reg_write  <= 1'b0;
      r_write_reg  <= '0;
      r_write_data <= '0;
      r_grant_cnt  <= '0;
    end else if (w_xfer) begin
      r_rr_ptr     <= (int'(w_win) == NREQ-1) ? '0 : w_win + 1'b1;
      r_reg_write  <= (w_addr != '0);
      r_write_reg  <= w_addr;
      r_write_data <= w_data;
      r_grant_cnt  <= r_grant_cnt + 16'd1;
    end else begin
      r_reg_write  <= 1'b0;
    end
  end

  // A claim landing on the same edge as a commit wins: the newer producer is still pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy[0] <= 1'b0;
      for (int r = 1; r < REG_NUM; r++) begin
        if (claim_valid && claim_addr == AW'(r))
          r_busy[r] <= 1'b1;
        else if (r_reg_write && r_write_reg == AW'(r))
          r_busy[r] <= 1'b0;
      end
    end
  end

  assign busy_1     = r_busy[query_addr_1];
  assign busy_2     = r_busy[query_addr_2];
  assign reg_write  = r_reg_write;
  assign write_reg  = r_write_reg;
  assign write_data = r_write_data;
  assign grant_cnt  = r_grant_cnt;
endmodule
